// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared Q8.24 format constants, scale coefficients and sample type for the Goertzel datapath
package goertzel_pkg;
  localparam int FRAC_W = 24;
  localparam int INT_W = 8;
  localparam int Q_W = FRAC_W + INT_W;
  localparam logic [31:0] SCALE_COEF = 32'h000D_0000;
  localparam logic [31:0] INV_COEF = 32'h13B1_3B14;
  localparam int PROD_FRAC_W = 2 * FRAC_W;
  typedef logic signed [Q_W-1:0] q8_24_t;
  typedef logic signed [63:0] q16_48_t;
endpackage

// File: rtl/unscale_sat.sv
// unscale_sat: rounds a Q16.48 product half-up to an integer and clips it to an 8-bit unsigned code
// Ports: p (Q16.48 signed product) -> d (8-bit code), sat (set when p < 0 or the rounded value exceeds 255)
module unscale_sat
  import goertzel_pkg::*;
(
  input  q16_48_t    p,
  output logic [7:0] d,
  output logic       sat
);
  localparam q16_48_t HALF = q16_48_t'(64'sd1 <<< (PROD_FRAC_W - 1));
  logic [15:0] r;
  logic neg, ovf;
  assign r = 16'((p + HALF) >>> PROD_FRAC_W);
  assign neg = p[63];
  assign ovf = |r[15:8];
  assign sat = neg || ovf;
  assign d = neg ? 8'd0 : ovf ? 8'd255 : r[7:0];
endmodule

// File: rtl/data_unscale.sv
// data_unscale: multiplies Q8.24 samples by 256/13, rounds and saturates to 8 bits through a 2-stage stallable valid/ready pipeline
// Ports: clk, rstn (sync, active-low); s_valid/s_ready/s_data (signed Q8.24 in);
//        m_valid/m_ready/m_data/m_sat/m_last (8-bit code, clip flag, last of each BLOCK_LEN-output block)
module data_unscale
  import goertzel_pkg::q8_24_t;
#(
  parameter logic [31:0] INV_COEF = goertzel_pkg::INV_COEF,
  parameter int unsigned BLOCK_LEN = 205,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_sat,
  output logic        m_last
);
  localparam logic signed [32:0] COEF = $signed({1'b0, INV_COEF});
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  logic v1, v2, adv1, adv2, sat;
  logic signed [63:0] p1;
  logic [7:0] d;
  logic [CNT_W-1:0] cnt;
  q8_24_t x;
  assign x = q8_24_t'(s_data);
  assign adv2 = !v2 || m_ready;
  assign adv1 = !v1 || adv2;
  assign s_ready = adv1;
  assign m_valid = v2;
  // gated by v2 so the flag is low while idle and during reset, even for BLOCK_LEN = 1
  assign m_last = v2 && (cnt == LAST_IDX);
  unscale_sat u_sat (
    .p  (p1),
    .d  (d),
    .sat(sat)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      m_data <= '0;
      m_sat <= 1'b0;
      cnt <= '0;
    end else begin
      if (adv1) begin
        v1 <= s_valid;
        p1 <= 64'(x) * 64'(COEF);
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          m_data <= d;
          m_sat <= sat;
        end
      end
      if (v2 && m_ready) cnt <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_data_unscale.sv
// tb_data_unscale: directed and streamed vectors for data_unscale with BLOCK_LEN = 4
module tb_data_unscale;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] s_data = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [7:0] m_data;
  logic m_sat;
  logic m_last;
  int n_vec = 0;
  int n_bad = 0;
  int outs = 0;
  int cyc = 0;
  int last_cyc = -1;
  int n_acc = 0;
  bit burst = 1'b0;
  bit stalled = 1'b0;
  logic [9:0] held;
  logic [8:0] q[$];
  always #5 clk = ~clk;
  data_unscale #(.BLOCK_LEN(4)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sat  (m_sat),
    .m_last (m_last)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [31:0] v);
    longint p, r;
    p = longint'($signed(v)) * longint'(32'h13B1_3B14);
    if (p < 0) return {1'b1, 8'd0};
    r = (p + (longint'(1) << 47)) / (longint'(1) << 48);
    return (r > 255) ? {1'b1, 8'd255} : {1'b0, 8'(r)};
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_msat", m_sat, 0);
    chk("rst_mlast", m_last, 0);
    rstn = 1'b1;
    #1;
    chk("rst_sready", s_ready, 1);
    q.delete();
    outs = 0;
    stalled = 1'b0;
  endtask
  task automatic vec(input string tag, input logic [31:0] v, input logic [7:0] ed, input logic es);
    @(negedge clk);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = v;
    #1;
    chk({tag, "_sready"}, s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    chk({tag, "_lat"}, m_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, m_valid, 1);
    chk(tag, {m_last, m_sat, m_data}, {outs % 4 == 3, es, ed});
    outs++;
  endtask
  task automatic cycle(input bit rdy, input bit want, input logic [31:0] v);
    @(negedge clk);
    if (stalled) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_out", {m_last, m_sat, m_data}, held);
    end
    m_ready = rdy;
    s_valid = 1'b0;
    #1;
    chk("s_ready", s_ready, !(q.size() == 2 && !rdy));
    stalled = m_valid && !rdy;
    held = {m_last, m_sat, m_data};
    if (m_valid && rdy) begin
      if (q.size() == 0) chk("spurious_valid", m_valid, 0);
      else begin
        chk("out", {m_last, m_sat, m_data}, {outs % 4 == 3, q.pop_front()});
        outs++;
        if (burst && last_cyc >= 0) chk("gap", cyc - last_cyc, 1);
        last_cyc = cyc;
      end
    end
    if (want) begin
      s_valid = 1'b1;
      s_data = v;
      if (s_ready) begin
        q.push_back(model(v));
        n_acc++;
      end
    end
    cyc++;
  endtask
  function automatic logic [31:0] rnd();
    return $urandom_range(32'h0E00_0000) - 32'h0080_0000;
  endfunction
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b1, 1'b0, '0);
    chk(tag, q.size(), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int stall;
    bit r;
    repeat (2) @(negedge clk);
    do_reset();
    vec("rt100", 32'h0514_0000, 8'd100, 1'b0);
    vec("rt255", 32'h0CF3_0000, 8'd255, 1'b0);
    vec("sat16", 32'h1000_0000, 8'd255, 1'b1);
    vec("neg1", 32'hFF00_0000, 8'd0, 1'b1);
    vec("zero", 32'h0000_0000, 8'd0, 1'b0);
    vec("tiny", 32'h0000_0D00, 8'd0, 1'b0);
    vec("half", 32'h0006_8000, 8'd1, 1'b0);
    vec("below_half", 32'h0006_7FFF, 8'd0, 1'b0);
    vec("r256", 32'h0CF9_8000, 8'd255, 1'b1);
    vec("r255_5m", 32'h0CF9_7FFF, 8'd255, 1'b0);
    vec("maxpos", 32'h7FFF_FFFF, 8'd255, 1'b1);
    vec("maxneg", 32'h8000_0000, 8'd0, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    burst = 1'b1;
    last_cyc = -1;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, rnd());
    drain("burst_drain");
    chk("burst_outs", outs, 32);
    burst = 1'b0;
    for (int i = 0; i < 80; i++) cycle(1'($urandom_range(1)), $urandom_range(3) != 0, rnd());
    drain("rand_drain");
    do_reset();
    n_acc = 0;
    stall = 3;
    for (int i = 0; i < 80 && (n_acc < 10 || q.size() != 0); i++) begin
      r = !(outs == 3 && stall > 0);
      cycle(r, n_acc < 10, rnd());
      if (!r && stalled) stall--;
    end
    chk("frame_stall_used", stall, 0);
    chk("frame_outs", outs, 10);
    chk("frame_empty", q.size(), 0);
    cycle(1'b0, 1'b1, 32'h0514_0000);
    cycle(1'b0, 1'b1, 32'h0CF3_0000);
    cycle(1'b0, 1'b1, 32'h1000_0000);
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 40 && (n_acc < 4 || q.size() != 0); i++) cycle(1'b1, n_acc < 4, rnd());
    chk("post_rst_outs", outs, 4);
    chk("post_rst_empty", q.size(), 0);
    @(negedge clk);
    s_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
